// File: rtl/lpc_sink_ram_fill_ctrl.sv
// Ping-pong fill controller: streams samples into the two halves of the sink RAM via port s2.
// Optional dropped-sample counter enabled by defining LPC_SINK_OVF_CNT_EN.
module lpc_sink_ram_fill_ctrl #(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAME_LEN = 1024,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              frame_ack,
  input  logic              ack_half,
  output logic              frame_done,
  output logic              done_half,
  output logic [1:0]        pending,
  output logic              overflow,
  output logic [CNT_W-1:0]  ovf_count,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_writedata,
  output logic [1:0]        ram_byteenable
);

  localparam int unsigned IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] IdxLast = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {StIdle, StFill, StStall} state_e;

  state_e              state_q, state_d;
  logic                cur_q, cur_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [1:0]          pending_q, pending_d;
  logic                overflow_q, overflow_d;
  logic                frame_done_q, frame_done_d;
  logic                done_half_q, done_half_d;
  logic                ram_write_q, ram_write_d;
  logic [ADDR_W-1:0]   ram_address_q, ram_address_d;
  logic [DATA_W-1:0]   ram_writedata_q, ram_writedata_d;
  logic                can_fill, accept, drop, ovf_clr, other_half;

  assign in_ready = enable;

  always_comb begin
    state_d         = state_q;
    cur_d           = cur_q;
    idx_d           = idx_q;
    pending_d       = pending_q;
    overflow_d      = overflow_q;
    frame_done_d    = 1'b0;
    done_half_d     = done_half_q;
    ram_write_d     = 1'b0;
    ram_address_d   = ram_address_q;
    ram_writedata_d = ram_writedata_q;
    ovf_clr         = 1'b0;
    other_half      = ~cur_q;

    // A stalled half that has just been released accepts in the same cycle.
    can_fill = (state_q == StFill) || ((state_q == StStall) && !pending_q[cur_q]);
    accept   = in_valid && in_ready && can_fill;
    drop     = in_valid && in_ready && (state_q == StStall) && pending_q[cur_q];

    if (frame_ack) pending_d[ack_half] = 1'b0;

    if (!enable) begin
      state_d = StIdle;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          ovf_clr = 1'b1;
          state_d = pending_q[cur_q] ? StStall : StFill;
        end
        StFill, StStall: begin
          if (accept) begin
            ram_write_d     = 1'b1;
            ram_address_d   = ADDR_W'({cur_q, idx_q});
            ram_writedata_d = in_data;
            state_d         = StFill;
            if (idx_q == IdxLast) begin
              idx_d              = '0;
              pending_d[cur_q]   = 1'b1;  // set wins over a same-half ack
              frame_done_d       = 1'b1;
              done_half_d        = cur_q;
              cur_d              = other_half;
              state_d            = pending_d[other_half] ? StStall : StFill;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else if (state_q == StStall && !pending_q[cur_q]) begin
            state_d = StFill;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (ovf_clr) overflow_d = 1'b0;
    else if (drop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      cur_q           <= 1'b0;
      idx_q           <= '0;
      pending_q       <= '0;
      overflow_q      <= 1'b0;
      frame_done_q    <= 1'b0;
      done_half_q     <= 1'b0;
      ram_write_q     <= 1'b0;
      ram_address_q   <= '0;
      ram_writedata_q <= '0;
    end else begin
      state_q         <= state_d;
      cur_q           <= cur_d;
      idx_q           <= idx_d;
      pending_q       <= pending_d;
      overflow_q      <= overflow_d;
      frame_done_q    <= frame_done_d;
      done_half_q     <= done_half_d;
      ram_write_q     <= ram_write_d;
      ram_address_q   <= ram_address_d;
      ram_writedata_q <= ram_writedata_d;
    end
  end

`ifdef LPC_SINK_OVF_CNT_EN
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_clr) ovf_cnt_d = '0;
    else if (drop && ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_cnt_q <= '0;
    else       ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_count = ovf_cnt_q;
`else
  assign ovf_count = '0;
`endif

  assign frame_done     = frame_done_q;
  assign done_half      = done_half_q;
  assign pending        = pending_q;
  assign overflow       = overflow_q;
  assign ram_chipselect = ram_write_q;
  assign ram_write      = ram_write_q;
  assign ram_address    = ram_address_q;
  assign ram_writedata  = ram_writedata_q;
  assign ram_byteenable = 2'b11;

endmodule
